// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch path.
// Contents: PC/instruction widths, the NOP encoding, the fetch FSM state
// type and a PC-advance helper that wraps modulo 2^PC_W.
package cpu_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Sequential PC step; the adder is PC_W bits wide, so it wraps silently.
    function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] pc,
                                                   input logic [PC_W-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry hold buffer for a fetched word that arrived while the
// downstream stage was stalled.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture load_pc/load_data and mark the entry full
//   unload              mark the entry empty (contents are being consumed)
//   clear               discard the entry (redirect); beats load and unload
//   load_pc, load_data  word and its PC to capture
//   full                entry holds a word
//   buf_pc, buf_data    captured PC and word
module fetch_skid_buffer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [PC_W-1:0]    load_pc,
    input  logic [INSTR_W-1:0] load_data,
    output logic               full,
    output logic [PC_W-1:0]    buf_pc,
    output logic [INSTR_W-1:0] buf_data
);

    logic               full_r;
    logic [PC_W-1:0]    pc_r;
    logic [INSTR_W-1:0] data_r;

    // Buffer storage: clear has priority so a redirect always empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
            pc_r   <= '0;
            data_r <= '0;
        end else if (clear) begin
            full_r <= 1'b0;
            pc_r   <= '0;
            data_r <= '0;
        end else if (load) begin
            full_r <= 1'b1;
            pc_r   <= load_pc;
            data_r <= load_data;
        end else if (unload) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    assign full     = full_r;
    assign buf_pc   = pc_r;
    assign buf_data = data_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one outstanding instruction-memory request
// at a time, presents fetched words to the IF/ID register and handles
// stalls (via a one-entry hold buffer) and branch redirects.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   stall_in         IF/ID cannot accept; outputs hold
//   branch_taken     one-cycle redirect pulse, branch_target sampled with it
//   imem_req/addr    memory request and its address (registered)
//   imem_ack/rdata   memory completion and word, valid in the ack cycle
//   pc_out, instruction_out, valid_out   registered fetch result
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 10'h000,
    parameter int              PC_INC   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_in,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               valid_out
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

    fetch_state_e       state_r, state_nxt_s;
    logic               req_r;
    logic [PC_W-1:0]    addr_r, addr_nxt_s;
    logic [PC_W-1:0]    pc_r, pc_nxt_s;
    logic [INSTR_W-1:0] instr_r, instr_nxt_s;
    logic               valid_r, valid_nxt_s;
    logic [PC_W-1:0]    target_r, target_nxt_s;

    logic               ack_s;
    logic               buf_load_s, buf_unload_s, buf_clear_s;
    logic               buf_full_s;
    logic [PC_W-1:0]    buf_pc_s;
    logic [INSTR_W-1:0] buf_data_s;

    // An ack only counts against a request we actually raised; this also
    // drops acks seen in the first cycle after reset, before imem_req rises.
    assign ack_s = imem_ack & req_r;

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load_s),
        .unload    (buf_unload_s),
        .clear     (buf_clear_s),
        .load_pc   (addr_r),
        .load_data (imem_rdata),
        .full      (buf_full_s),
        .buf_pc    (buf_pc_s),
        .buf_data  (buf_data_s)
    );

    // Next-state, next-output and hold-buffer control.
    always_comb begin
        state_nxt_s  = state_r;
        addr_nxt_s   = addr_r;
        pc_nxt_s     = pc_r;
        instr_nxt_s  = instr_r;
        valid_nxt_s  = valid_r;
        target_nxt_s = target_r;
        buf_load_s   = 1'b0;
        buf_unload_s = 1'b0;
        buf_clear_s  = 1'b0;

        case (state_r)
            FETCH: begin
                if (branch_taken) begin
                    valid_nxt_s = 1'b0;
                    instr_nxt_s = NOP_INSTR;
                    buf_clear_s = 1'b1;
                    if (req_r && !ack_s) begin
                        // Request still in flight: wait it out before redirecting.
                        state_nxt_s  = DRAIN;
                        target_nxt_s = branch_target;
                    end else begin
                        state_nxt_s = FETCH;
                        addr_nxt_s  = branch_target;
                    end
                end else if (ack_s) begin
                    if (stall_in) begin
                        buf_load_s  = 1'b1;
                        state_nxt_s = HOLD;
                    end else begin
                        pc_nxt_s    = addr_r;
                        instr_nxt_s = imem_rdata;
                        valid_nxt_s = 1'b1;
                        addr_nxt_s  = pc_advance(addr_r, PC_STEP);
                    end
                end else if (stall_in) begin
                    valid_nxt_s = valid_r;
                end else begin
                    // Previous word was consumed and nothing new arrived: bubble.
                    valid_nxt_s = 1'b0;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    valid_nxt_s = 1'b0;
                    instr_nxt_s = NOP_INSTR;
                    buf_clear_s = 1'b1;
                    addr_nxt_s  = branch_target;
                    state_nxt_s = FETCH;
                end else if (!stall_in) begin
                    pc_nxt_s     = buf_pc_s;
                    instr_nxt_s  = buf_data_s;
                    valid_nxt_s  = buf_full_s;
                    buf_unload_s = 1'b1;
                    addr_nxt_s   = pc_advance(buf_pc_s, PC_STEP);
                    state_nxt_s  = FETCH;
                end else begin
                    state_nxt_s = HOLD;
                end
            end

            DRAIN: begin
                if (branch_taken) begin
                    // The newest redirect wins over any saved one.
                    valid_nxt_s  = 1'b0;
                    instr_nxt_s  = NOP_INSTR;
                    buf_clear_s  = 1'b1;
                    target_nxt_s = branch_target;
                    if (ack_s) begin
                        addr_nxt_s  = branch_target;
                        state_nxt_s = FETCH;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else if (ack_s) begin
                    addr_nxt_s  = target_r;
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end

            default: begin
                state_nxt_s = FETCH;
                addr_nxt_s  = RESET_PC;
                valid_nxt_s = 1'b0;
                instr_nxt_s = NOP_INSTR;
                buf_clear_s = 1'b1;
            end
        endcase
    end

    // State, request and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= FETCH;
            req_r    <= 1'b0;
            addr_r   <= RESET_PC;
            pc_r     <= RESET_PC;
            instr_r  <= NOP_INSTR;
            valid_r  <= 1'b0;
            target_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            req_r    <= (state_nxt_s != HOLD);
            addr_r   <= addr_nxt_s;
            pc_r     <= pc_nxt_s;
            instr_r  <= instr_nxt_s;
            valid_r  <= valid_nxt_s;
            target_r <= target_nxt_s;
        end
    end

    assign imem_req        = req_r;
    assign imem_addr       = addr_r;
    assign pc_out          = pc_r;
    assign instruction_out = instr_r;
    assign valid_out       = valid_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit (RESET_PC=0, PC_INC=4).
// Each table row gives the inputs driven for one cycle and the registered
// outputs expected during that cycle (produced by the preceding edges).
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_in;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [9:0]  pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        stall;
        logic        br;
        logic [9:0]  tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [9:0]  e_addr;
        logic [9:0]  e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    instruction_fetch_unit #(
        .RESET_PC (10'h000),
        .PC_INC   (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_in        (stall_in),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic e_req, input logic [9:0] e_addr,
                             input logic [9:0] e_pc, input logic [31:0] e_instr,
                             input logic e_valid);
        check("imem_req",        idx, 32'(imem_req),        32'(e_req));
        check("imem_addr",       idx, 32'(imem_addr),       32'(e_addr));
        check("pc_out",          idx, 32'(pc_out),          32'(e_pc));
        check("instruction_out", idx, instruction_out,      e_instr);
        check("valid_out",       idx, 32'(valid_out),       32'(e_valid));
    endtask

    task automatic add(input logic s, input logic b, input logic [9:0] t,
                       input logic a, input logic [31:0] d,
                       input logic er, input logic [9:0] ea, input logic [9:0] ep,
                       input logic [31:0] ei, input logic ev);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.ack = a; v.rdata = d;
        v.e_req = er; v.e_addr = ea; v.e_pc = ep; v.e_instr = ei; v.e_valid = ev;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        stall_in = 1'b0;
        branch_taken = 1'b0;
        branch_target = 10'h000;
        imem_ack = 1'b1;               // acks during reset must be ignored
        imem_rdata = 32'hBAD0_BAD0;

        //   stall br  tgt     ack rdata          | req addr    pc      instr          valid
        // zero-wait streaming from reset
        add(1'b0, 1'b0, 10'h000, 1'b0, 32'h0000_0000, 1'b0, 10'h000, 10'h000, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 32'hA000_0000, 1'b1, 10'h000, 10'h000, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 32'hA000_0004, 1'b1, 10'h004, 10'h000, 32'hA000_0000, 1'b1);
        add(1'b0, 1'b0, 10'h000, 1'b1, 32'hA000_0008, 1'b1, 10'h008, 10'h004, 32'hA000_0004, 1'b1);
        add(1'b0, 1'b0, 10'h000, 1'b1, 32'hA000_000C, 1'b1, 10'h00C, 10'h008, 32'hA000_0008, 1'b1);
        // ack at 0x010 under stall, stall held three cycles
        add(1'b1, 1'b0, 10'h000, 1'b1, 32'hB000_0010, 1'b1, 10'h010, 10'h00C, 32'hA000_000C, 1'b1);
        add(1'b1, 1'b0, 10'h000, 1'b0, 32'h0000_0000, 1'b0, 10'h010, 10'h00C, 32'hA000_000C, 1'b1);
        add(1'b1, 1'b0, 10'h000, 1'b0, 32'h0000_0000, 1'b0, 10'h010, 10'h00C, 32'hA000_000C, 1'b1);
        add(1'b0, 1'b0, 10'h000, 1'b0, 32'h0000_0000, 1'b0, 10'h010, 10'h00C, 32'hA000_000C, 1'b1);
        add(1'b0, 1'b0, 10'h000, 1'b0, 32'h0000_0000, 1'b1, 10'h014, 10'h010, 32'hB000_0010, 1'b1);
        add(1'b0, 1'b0, 10'h000, 1'b1, 32'hB000_0014, 1'b1, 10'h014, 10'h010, 32'hB000_0010, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 32'hB000_0018, 1'b1, 10'h018, 10'h014, 32'hB000_0014, 1'b1);
        add(1'b0, 1'b0, 10'h000, 1'b1, 32'hB000_001C, 1'b1, 10'h01C, 10'h018, 32'hB000_0018, 1'b1);
        // branch to 0x200 while 0x020 waits two cycles for its ack
        add(1'b0, 1'b1, 10'h200, 1'b0, 32'h0000_0000, 1'b1, 10'h020, 10'h01C, 32'hB000_001C, 1'b1);
        add(1'b0, 1'b0, 10'h000, 1'b0, 32'h0000_0000, 1'b1, 10'h020, 10'h01C, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b0, 32'h0000_0000, 1'b1, 10'h020, 10'h01C, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 32'hDEAD_BEEF, 1'b1, 10'h020, 10'h01C, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 32'hC000_0200, 1'b1, 10'h200, 10'h01C, 32'h0000_0000, 1'b0);
        // branch + stall + ack in one cycle, target 0x3FC
        add(1'b1, 1'b1, 10'h3FC, 1'b1, 32'hEEEE_EEEE, 1'b1, 10'h204, 10'h200, 32'hC000_0200, 1'b1);
        add(1'b0, 1'b0, 10'h000, 1'b1, 32'hF000_03FC, 1'b1, 10'h3FC, 10'h200, 32'h0000_0000, 1'b0);
        // wrap to 0x000; stall without ack holds outputs; then bubble
        add(1'b1, 1'b0, 10'h000, 1'b0, 32'h0000_0000, 1'b1, 10'h000, 10'h3FC, 32'hF000_03FC, 1'b1);
        add(1'b0, 1'b0, 10'h000, 1'b0, 32'h0000_0000, 1'b1, 10'h000, 10'h3FC, 32'hF000_03FC, 1'b1);
        // enter HOLD, then branch out of it to 0x100 (buffer discarded)
        add(1'b1, 1'b0, 10'h000, 1'b1, 32'h1111_1111, 1'b1, 10'h000, 10'h3FC, 32'hF000_03FC, 1'b0);
        add(1'b1, 1'b1, 10'h100, 1'b0, 32'h0000_0000, 1'b0, 10'h000, 10'h3FC, 32'hF000_03FC, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 32'h2222_0100, 1'b1, 10'h100, 10'h3FC, 32'h0000_0000, 1'b0);
        // two branches during DRAIN: latest target (0x0C0) wins
        add(1'b0, 1'b1, 10'h080, 1'b0, 32'h0000_0000, 1'b1, 10'h104, 10'h100, 32'h2222_0100, 1'b1);
        add(1'b0, 1'b1, 10'h0C0, 1'b0, 32'h0000_0000, 1'b1, 10'h104, 10'h100, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 32'h3333_3333, 1'b1, 10'h104, 10'h100, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b0, 32'h0000_0000, 1'b1, 10'h0C0, 10'h100, 32'h0000_0000, 1'b0);

        // reset state while held in reset across edges with ack asserted
        repeat (2) @(negedge clk);
        check_all(-1, 1'b0, 10'h000, 10'h000, 32'h0000_0000, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            stall_in      = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            imem_ack      = vecs[i].ack;
            imem_rdata    = vecs[i].rdata;
            check_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pc,
                      vecs[i].e_instr, vecs[i].e_valid);
            @(negedge clk);
        end

        // Reset asserted while in DRAIN: branch with request pending, then reset.
        stall_in = 1'b0;
        branch_taken = 1'b1;
        branch_target = 10'h2A0;
        imem_ack = 1'b0;
        @(negedge clk);
        branch_taken = 1'b0;
        branch_target = 10'h000;
        check_all(100, 1'b1, 10'h0C0, 10'h100, 32'h0000_0000, 1'b0);
        imem_ack = 1'b1;
        imem_rdata = 32'h7777_7777;
        #1 rst_n = 1'b0;
        #1 check_all(101, 1'b0, 10'h000, 10'h000, 32'h0000_0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b0;
        check_all(102, 1'b0, 10'h000, 10'h000, 32'h0000_0000, 1'b0);
        @(negedge clk);
        check_all(103, 1'b1, 10'h000, 10'h000, 32'h0000_0000, 1'b0);
        imem_ack = 1'b1;
        imem_rdata = 32'h5555_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        check_all(104, 1'b1, 10'h004, 10'h000, 32'h5555_0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
